// File: rtl/rect_fill.sv
// Rectangle fill engine: walks a w x h rectangle in raster order, one pixel write strobe per cycle.
// Latency: first pixel the cycle after start is accepted, done pulses the cycle after the last pixel.
// No backpressure; start is only sampled when idle. Build option RECT_FILL_CLIP_EN suppresses off-screen plots.
module rect_fill #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [7:0]  x,
    input  logic [6:0]  y,
    input  logic [7:0]  w,
    input  logic [6:0]  h,
    input  logic [11:0] colour,
    output logic        busy,
    output logic        done,
    output logic        plot,
    output logic [15:0] buf_pos,
    output logic [11:0] colour_out
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [15:0] ROW_STEP = 16'(SCREEN_W);

    state_t      state, state_nxt;
    logic [7:0]  x_q;
    logic [11:0] colour_q;
    logic [8:0]  col, col_end;
    logic [7:0]  row, row_end;
    logic [15:0] row_base;
    logic        last_col, last_pix, in_view;

    assign last_col = (col == col_end);
    assign last_pix = last_col && (row == row_end);

`ifdef RECT_FILL_CLIP_EN
    assign in_view = (col < 9'(SCREEN_W)) && (row < 8'(SCREEN_H));
`else
    assign in_view = 1'b1;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        busy       = 1'b0;
        done       = 1'b0;
        plot       = 1'b0;
        buf_pos    = 16'd0;
        colour_out = 12'd0;
        case (state)
            IDLE: begin
                if (start) state_nxt = (w != 8'd0 && h != 7'd0) ? RUN : DONE;
            end
            RUN: begin
                busy       = 1'b1;
                plot       = in_view;
                buf_pos    = row_base + 16'(col);
                colour_out = in_view ? colour_q : 12'd0;
                if (last_pix) state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // End coordinates are computed once at acceptance in 9/8 bits so they never wrap.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            x_q      <= 8'd0;
            colour_q <= 12'd0;
            col      <= 9'd0;
            col_end  <= 9'd0;
            row      <= 8'd0;
            row_end  <= 8'd0;
            row_base <= 16'd0;
        end else if (state == IDLE && start) begin
            x_q      <= x;
            colour_q <= colour;
            col      <= {1'b0, x};
            col_end  <= {1'b0, x} + {1'b0, w} - 9'd1;
            row      <= {1'b0, y};
            row_end  <= {1'b0, y} + {1'b0, h} - 8'd1;
            row_base <= 16'(y) * ROW_STEP;
        end else if (state == RUN) begin
            if (last_col) begin
                col      <= {1'b0, x_q};
                row      <= row + 8'd1;
                row_base <= row_base + ROW_STEP;
            end else begin
                col <= col + 9'd1;
            end
        end
    end

endmodule

// File: tb/tb_rect_fill.sv
// Directed bench for rect_fill: fixed rectangles with hand-computed pixel addresses.
module tb_rect_fill;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  x = 8'd0;
    logic [6:0]  y = 7'd0;
    logic [7:0]  w = 8'd0;
    logic [6:0]  h = 7'd0;
    logic [11:0] colour = 12'd0;
    logic        busy, done, plot;
    logic [15:0] buf_pos;
    logic [11:0] colour_out;

    int          n_vec = 0;
    int          n_bad = 0;
    logic [15:0] pq[$];
    int          colbad;
    logic [11:0] cur_colour;

    rect_fill dut (
        .clk(clk), .resetn(resetn), .start(start), .x(x), .y(y), .w(w), .h(h),
        .colour(colour), .busy(busy), .done(done), .plot(plot),
        .buf_pos(buf_pos), .colour_out(colour_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Request is presented for exactly one rising edge; returns at the first post-acceptance negedge.
    task automatic send(input logic [7:0] xi, input logic [6:0] yi, input logic [7:0] wi,
                        input logic [6:0] hi, input logic [11:0] ci);
        @(negedge clk);
        x = xi; y = yi; w = wi; h = hi; colour = ci; start = 1'b1;
        cur_colour = ci;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Samples each cycle until done; logs plotted addresses and checks the cycle after done.
    task automatic collect(input string tag, output int runc, output int dones);
        bit fin;
        pq.delete();
        runc = 0; dones = 0; colbad = 0; fin = 0;
        for (int k = 0; k < 25000; k++) begin
            if (done) begin
                dones++;
                fin = 1;
                @(negedge clk);
                chk({tag, "_busy_after_done"}, 32'(busy), 32'd0);
                chk({tag, "_done_width"}, 32'(done), 32'd0);
                break;
            end
            if (busy) runc++;
            if (plot) begin
                pq.push_back(buf_pos);
                if (colour_out !== cur_colour) colbad++;
            end
            @(negedge clk);
        end
        if (!fin) chk({tag, "_timeout"}, 32'(fin), 32'd1);
    endtask

    initial begin
        int runc, dones, gaps;

        #3;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_plot", 32'(plot), 32'd0);
        chk("rst_buf_pos", 32'(buf_pos), 32'd0);
        chk("rst_colour_out", 32'(colour_out), 32'd0);
        @(negedge clk);
        resetn = 1'b1;

        // 2x2 at origin
        send(8'd0, 7'd0, 8'd2, 7'd2, 12'hF00);
        collect("sq2", runc, dones);
        chk("sq2_runc", 32'(runc), 32'd4);
        chk("sq2_plots", 32'(pq.size()), 32'd4);
        chk("sq2_p0", 32'(pq[0]), 32'd0);
        chk("sq2_p1", 32'(pq[1]), 32'd1);
        chk("sq2_p2", 32'(pq[2]), 32'd160);
        chk("sq2_p3", 32'(pq[3]), 32'd161);
        chk("sq2_colour", 32'(colbad), 32'd0);
        chk("sq2_done", 32'(dones), 32'd1);

        // Bottom-right corner straddling the screen edge
        send(8'd159, 7'd119, 8'd2, 7'd2, 12'h0A5);
        collect("corner", runc, dones);
        chk("corner_runc", 32'(runc), 32'd4);
`ifdef RECT_FILL_CLIP_EN
        chk("corner_plots", 32'(pq.size()), 32'd1);
        chk("corner_p0", 32'(pq[0]), 32'd19199);
`else
        chk("corner_plots", 32'(pq.size()), 32'd4);
        chk("corner_p0", 32'(pq[0]), 32'd19199);
        chk("corner_p1", 32'(pq[1]), 32'd19200);
        chk("corner_p2", 32'(pq[2]), 32'd19359);
        chk("corner_p3", 32'(pq[3]), 32'd19360);
`endif
        chk("corner_colour", 32'(colbad), 32'd0);

        // Zero width: straight to DONE
        send(8'd20, 7'd10, 8'd0, 7'd5, 12'h123);
        chk("zw_done", 32'(done), 32'd1);
        chk("zw_busy", 32'(busy), 32'd1);
        chk("zw_plot", 32'(plot), 32'd0);
        @(negedge clk);
        chk("zw_busy_after", 32'(busy), 32'd0);
        chk("zw_done_after", 32'(done), 32'd0);

        // start during RUN with a different x must be ignored
        send(8'd10, 7'd5, 8'd3, 7'd2, 12'h0F0);
        chk("ign_first_plot", 32'(plot), 32'd1);
        chk("ign_first_pos", 32'(buf_pos), 32'd810);
        x = 8'd50; w = 8'd1; h = 7'd1; colour = 12'hFFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        collect("ign", runc, dones);
        chk("ign_rest_plots", 32'(pq.size()), 32'd5);
        chk("ign_p0", 32'(pq[0]), 32'd811);
        chk("ign_p1", 32'(pq[1]), 32'd812);
        chk("ign_p2", 32'(pq[2]), 32'd970);
        chk("ign_p4", 32'(pq[4]), 32'd972);
        chk("ign_colour", 32'(colbad), 32'd0);

        // Reset mid-RUN: outputs drop without a clock edge, no done afterwards
        send(8'd0, 7'd0, 8'd4, 7'd4, 12'h00F);
        @(negedge clk);
        @(negedge clk);
        chk("mid_busy_before", 32'(busy), 32'd1);
        #2 resetn = 1'b0;
        #1;
        chk("mid_rst_plot", 32'(plot), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_pos", 32'(buf_pos), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        dones = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done || busy) dones++;
        end
        chk("mid_rst_quiet", 32'(dones), 32'd0);
        send(8'd0, 7'd0, 8'd2, 7'd2, 12'hF00);
        collect("post_rst", runc, dones);
        chk("post_rst_plots", 32'(pq.size()), 32'd4);
        chk("post_rst_p3", 32'(pq[3]), 32'd161);
        chk("post_rst_done", 32'(dones), 32'd1);

        // Full screen, contiguous addresses
        send(8'd0, 7'd0, 8'd160, 7'd120, 12'h5A5);
        collect("full", runc, dones);
        chk("full_runc", 32'(runc), 32'd19200);
        chk("full_plots", 32'(pq.size()), 32'd19200);
        gaps = 0;
        foreach (pq[i]) if (pq[i] != 16'(i)) gaps++;
        chk("full_contig", 32'(gaps), 32'd0);
        chk("full_colour", 32'(colbad), 32'd0);
        chk("full_done", 32'(dones), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
